// File: rtl/usbfs_pkt_tx_gen2.sv
// usbfs_pkt_tx_gen2: full-speed USB packet serialiser (SYNC/PID/field/CRC/EOP, NRZI, bit stuffing); define USBFS_PKT_TX_ABORT_EN to build the abort path
module usbfs_pkt_tx_gen2 #(
  parameter int MAX_PKT = 64,
  localparam int NBYTES_W = $clog2(MAX_PKT + 1),
  localparam int IDX_W = $clog2(MAX_PKT)
) (
  input  logic                i_clk_12MHz,
  input  logic                i_rst_n,
  output logic                o_ready,
  input  logic                i_valid,
  input  logic [3:0]          i_pid,
  input  logic [10:0]         i_tokenField,
  input  logic [NBYTES_W-1:0] i_nBytes,
  input  logic                i_wrEn,
  input  logic [IDX_W-1:0]    i_wrIdx,
  input  logic [7:0]          i_wrByte,
  input  logic                i_abort,
  output logic                o_dp,
  output logic                o_dn,
  output logic                o_oe,
  output logic                o_eopDone,
  output logic                o_aborted
);
  typedef enum logic [2:0] {IDLE, SYNC, PID, FIELD, DATA, CRC, EOP
`ifdef USBFS_PKT_TX_ABORT_EN
    , ABORT
`endif
  } state_t;
  state_t st_q, st_d;
  logic [3:0] cnt_q, cnt_d, pid_q, pid_d;
  logic [10:0] fld_q, fld_d;
  logic [NBYTES_W-1:0] nb_q, nb_d, byte_q, byte_d;
  logic [2:0] run_q, run_d;
  logic [4:0] crc5_q, crc5_d;
  logic [15:0] crc16_q, crc16_d;
  logic dp_q, dp_d, dn_q, dn_d, oe_q, oe_d, eop_q, eop_d, abt_q, abt_d;
  logic [7:0] mem_q [MAX_PKT];
  logic [7:0] pid_byte, cur_byte;
  logic accept, tx, tok, last, bit_v, fb5, fb16;
  assign o_ready = st_q == IDLE && !oe_q;
  assign accept = i_valid && o_ready;
  assign tx = st_q inside {SYNC, PID, FIELD, DATA, CRC};
  assign tok = pid_q[1:0] == 2'b01;
  assign pid_byte = {~pid_q, pid_q};
  assign cur_byte = mem_q[byte_q[IDX_W-1:0]];
  assign fb5 = bit_v ^ crc5_q[4];
  assign fb16 = bit_v ^ crc16_q[0];
  assign o_dp = dp_q;
  assign o_dn = dn_q;
  assign o_oe = oe_q;
  assign o_eopDone = eop_q;
`ifdef USBFS_PKT_TX_ABORT_EN
  assign o_aborted = eop_q && abt_q;
`else
  logic unused_abort;
  assign unused_abort = i_abort;
  assign o_aborted = 1'b0;
`endif
  // payload buffer: only loaded while the transmitter is idle
  always_ff @(posedge i_clk_12MHz)
    if (i_wrEn && o_ready) mem_q[i_wrIdx] <= i_wrByte;
  // data bit of the current field and whether it closes that field
  always_comb begin
    bit_v = st_q == SYNC  ? cnt_q == 4'd7 :
            st_q == PID   ? pid_byte[cnt_q[2:0]] :
            st_q == FIELD ? fld_q[cnt_q] :
            st_q == DATA  ? cur_byte[cnt_q[2:0]] :
            tok           ? ~crc5_q[3'd4 - cnt_q[2:0]] : ~crc16_q[cnt_q];
    last = st_q == FIELD ? cnt_q == 4'd10 :
           st_q == CRC   ? cnt_q == (tok ? 4'd4 : 4'd15) : cnt_q == 4'd7;
  end
  // next state: one line bit per cycle, stuffed zeros hold all counters
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    pid_d = pid_q;
    fld_d = fld_q;
    nb_d = nb_q;
    byte_d = byte_q;
    run_d = run_q;
    crc5_d = crc5_q;
    crc16_d = crc16_q;
    dp_d = dp_q;
    dn_d = dn_q;
    oe_d = oe_q;
    eop_d = 1'b0;
    abt_d = abt_q;
    if (st_q == IDLE) begin
      oe_d = accept;
      dp_d = !accept;
      dn_d = accept;
      if (accept) begin
        st_d = SYNC;
        cnt_d = 4'd1;
        pid_d = i_pid;
        fld_d = i_tokenField;
        nb_d = i_nBytes > NBYTES_W'(MAX_PKT) ? NBYTES_W'(MAX_PKT) : i_nBytes;
        byte_d = '0;
        run_d = 3'd0;
        crc5_d = 5'h1F;
        crc16_d = 16'hFFFF;
        abt_d = 1'b0;
      end
`ifdef USBFS_PKT_TX_ABORT_EN
    end else if (tx && i_abort) begin
      st_d = ABORT;
      cnt_d = 4'd1;
      abt_d = 1'b1;
    end else if (st_q == ABORT) begin
      st_d = cnt_q == 4'd7 ? EOP : ABORT;
      cnt_d = cnt_q == 4'd7 ? 4'd0 : cnt_q + 4'd1;
`endif
    end else if (tx && run_q == 3'd6) begin
      dp_d = ~dp_q;
      dn_d = ~dn_q;
      run_d = 3'd0;
    end else if (tx) begin
      dp_d = dp_q ^ ~bit_v;
      dn_d = dn_q ^ ~bit_v;
      run_d = bit_v ? run_q + 3'd1 : 3'd0;
      cnt_d = last ? 4'd0 : cnt_q + 4'd1;
      if (st_q == FIELD) crc5_d = {crc5_q[3:0], 1'b0} ^ (fb5 ? 5'h05 : 5'h00);
      if (st_q == DATA) crc16_d = {1'b0, crc16_q[15:1]} ^ (fb16 ? 16'hA001 : 16'h0000);
      if (st_q == DATA && last) byte_d = byte_q + 1'b1;
      if (last)
        st_d = st_q == SYNC  ? PID :
               st_q == PID   ? (tok ? FIELD : pid_q[1:0] == 2'b11 ? (nb_q == '0 ? CRC : DATA) : EOP) :
               st_q == FIELD ? CRC :
               st_q == DATA  ? (byte_q + 1'b1 == nb_q ? CRC : DATA) : EOP;
    end else if (st_q == EOP) begin
      if (run_q == 3'd6 && !abt_q) begin
        dp_d = ~dp_q;
        dn_d = ~dn_q;
        run_d = 3'd0;
      end else begin
        dp_d = cnt_q == 4'd2;
        dn_d = 1'b0;
        eop_d = cnt_q == 4'd2;
        cnt_d = cnt_q == 4'd2 ? 4'd0 : cnt_q + 4'd1;
        st_d = cnt_q == 4'd2 ? IDLE : EOP;
      end
    end
  end
  // state registers; line parks at J with the pad released
  always_ff @(posedge i_clk_12MHz or negedge i_rst_n)
    if (!i_rst_n) begin
      st_q <= IDLE;
      cnt_q <= 4'd0;
      pid_q <= 4'd0;
      fld_q <= 11'd0;
      nb_q <= '0;
      byte_q <= '0;
      run_q <= 3'd0;
      crc5_q <= 5'h1F;
      crc16_q <= 16'hFFFF;
      dp_q <= 1'b1;
      dn_q <= 1'b0;
      oe_q <= 1'b0;
      eop_q <= 1'b0;
      abt_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      pid_q <= pid_d;
      fld_q <= fld_d;
      nb_q <= nb_d;
      byte_q <= byte_d;
      run_q <= run_d;
      crc5_q <= crc5_d;
      crc16_q <= crc16_d;
      dp_q <= dp_d;
      dn_q <= dn_d;
      oe_q <= oe_d;
      eop_q <= eop_d;
      abt_q <= abt_d;
    end
endmodule

// File: tb/tb_usbfs_pkt_tx_gen2.sv
// tb_usbfs_pkt_tx_gen2: directed bench decoding the NRZI line back into bits against a reference packet model
module tb_usbfs_pkt_tx_gen2;
  logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0, wr_en = 1'b0, abort = 1'b0;
  logic [3:0] pid = '0;
  logic [10:0] fld = '0;
  logic [6:0] nb = '0;
  logic [5:0] wr_idx = '0;
  logic [7:0] wr_byte = '0;
  logic ready, dp, dn, oe, eop, aborted;
  int checks = 0, failures = 0;
  logic [7:0] mem_m [64];
  logic [1023:0] exp_v, dec_v;
  int exp_n, dec_n, n_exp, n_line, stuff_cnt, first_stuff, stuff_err, se0_cnt, eop_cyc, rdy_cyc, d;
  bit j_ok, abt_seen;
  logic [1:0] lv [0:4095];

  always #5 clk = ~clk;

  usbfs_pkt_tx_gen2 dut (
    .i_clk_12MHz(clk), .i_rst_n(rst_n), .o_ready(ready), .i_valid(valid),
    .i_pid(pid), .i_tokenField(fld), .i_nBytes(nb), .i_wrEn(wr_en),
    .i_wrIdx(wr_idx), .i_wrByte(wr_byte), .i_abort(abort),
    .o_dp(dp), .o_dn(dn), .o_oe(oe), .o_eopDone(eop), .o_aborted(aborted)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic void build_exp(input logic [3:0] p, input logic [10:0] f, input int n);
    logic [4:0] c5;
    logic [15:0] c16;
    logic [7:0] b;
    bit fb;
    int run, st;
    exp_n = 0;
    exp_v = '0;
    b = 8'h80;
    for (int i = 0; i < 8; i++) begin exp_v[exp_n] = b[i]; exp_n++; end
    b = {~p, p};
    for (int i = 0; i < 8; i++) begin exp_v[exp_n] = b[i]; exp_n++; end
    if (p[1:0] == 2'b01) begin
      c5 = 5'h1F;
      for (int i = 0; i < 11; i++) begin
        exp_v[exp_n] = f[i]; exp_n++;
        fb = f[i] ^ c5[4];
        c5 = {c5[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
      end
      for (int i = 4; i >= 0; i--) begin exp_v[exp_n] = ~c5[i]; exp_n++; end
    end else if (p[1:0] == 2'b11) begin
      c16 = 16'hFFFF;
      for (int k = 0; k < n; k++) begin
        b = mem_m[k];
        for (int i = 0; i < 8; i++) begin
          exp_v[exp_n] = b[i]; exp_n++;
          fb = b[i] ^ c16[15];
          c16 = {c16[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
      end
      for (int i = 15; i >= 0; i--) begin exp_v[exp_n] = ~c16[i]; exp_n++; end
    end
    run = 0;
    st = 0;
    for (int i = 0; i < exp_n; i++) begin
      if (run == 6) begin st++; run = 0; end
      run = exp_v[i] ? run + 1 : 0;
    end
    if (run == 6) st++;
    n_exp = exp_n + st;
  endfunction

  function automatic int first_diff();
    for (int i = 0; i < 1024; i++)
      if (i >= exp_n || i >= dec_n) return (exp_n == dec_n) ? -1 : i;
      else if (dec_v[i] !== exp_v[i]) return i;
    return -1;
  endfunction

  task automatic wr(input int i, input logic [7:0] b);
    @(negedge clk);
    wr_en = 1'b1; wr_idx = 6'(i); wr_byte = b;
    mem_m[i] = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic send(input logic [3:0] p, input logic [10:0] f, input logic [6:0] n,
                      input int abort_cyc, input bit scribble);
    int run;
    logic [1:0] prev;
    bit done, b;
    build_exp(p, f, n > 64 ? 64 : int'(n));
    dec_v = '0; dec_n = 0; n_line = 0; stuff_cnt = 0; first_stuff = -1; stuff_err = 0;
    se0_cnt = 0; eop_cyc = -1; rdy_cyc = -1; j_ok = 0; abt_seen = 0;
    run = 0; prev = 2'b10; done = 0;
    @(negedge clk);
    pid = p; fld = f; nb = n; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    for (int cyc = 1; cyc < 3000 && !done; cyc++) begin
      lv[cyc] = {dp, dn};
      if (eop_cyc >= 0) begin
        rdy_cyc = (ready === 1'b1 && oe === 1'b0) ? cyc : -2;
        done = 1;
      end else if (eop === 1'b1) begin
        eop_cyc = cyc;
        j_ok = {dp, dn} === 2'b10 && oe === 1'b1;
        abt_seen = aborted === 1'b1;
      end else if ({dp, dn} === 2'b00) se0_cnt++;
      else begin
        n_line++;
        b = {dp, dn} === prev;
        prev = {dp, dn};
        if (run == 6 && !b) begin
          stuff_cnt++;
          if (first_stuff < 0) first_stuff = dec_n;
          run = 0;
        end else begin
          if (run >= 6) stuff_err++;
          if (dec_n < 1024) dec_v[dec_n] = b;
          dec_n++;
          run = b ? run + 1 : 0;
        end
      end
      abort = cyc == abort_cyc;
      valid = scribble && cyc >= 3 && cyc <= 8;
      wr_en = scribble && eop_cyc < 0;
      wr_idx = 6'(cyc % 4);
      wr_byte = 8'h5A;
      @(negedge clk);
    end
    abort = 1'b0; valid = 1'b0; wr_en = 1'b0;
    checks++;
    if (!done) begin failures++; $display("FAIL timeout pid=%0h got=no_eop exp=eop", p); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({dp, dn, oe, ready} !== 4'b1001) begin failures++; $display("FAIL reset_line got=%b exp=1001", {dp, dn, oe, ready}); end
    checks++;
    if ({eop, aborted} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b exp=00", {eop, aborted}); end
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 64; i++) wr(i, 8'(i * 37 + 11));
  endtask

  task automatic test_ack();
    send(4'h2, 11'h0, 7'd0, 0, 0);
    checks++;
    if (dec_v[15:0] !== 16'hD280) begin failures++; $display("FAIL ack_bytes got=%h exp=d280", dec_v[15:0]); end
    checks++;
    if (n_line != 16 || stuff_cnt != 0) begin failures++; $display("FAIL ack_n got=%0d/%0d exp=16/0", n_line, stuff_cnt); end
    checks++;
    if (eop_cyc != 19) begin failures++; $display("FAIL ack_eop got=%0d exp=19", eop_cyc); end
    checks++;
    if (rdy_cyc != 20) begin failures++; $display("FAIL ack_ready got=%0d exp=20", rdy_cyc); end
  endtask

  task automatic test_setup();
    send(4'hD, 11'h0, 7'd0, 0, 0);
    checks++;
    if (dec_v[31:0] !== 32'h10002D80) begin failures++; $display("FAIL setup_bytes got=%h exp=10002d80", dec_v[31:0]); end
    checks++;
    if (se0_cnt != 2 || !j_ok) begin failures++; $display("FAIL setup_eop got=se0:%0d j:%0d exp=se0:2 j:1", se0_cnt, j_ok); end
    checks++;
    if (n_line != 32 || eop_cyc != 35) begin failures++; $display("FAIL setup_n got=%0d/%0d exp=32/35", n_line, eop_cyc); end
  endtask

  task automatic test_sof();
    send(4'h5, 11'h7A5, 7'd0, 0, 0);
    d = first_diff();
    checks++;
    if (d != -1) begin failures++; $display("FAIL sof_bits got=diff_at_%0d exp=none", d); end
    checks++;
    if (n_line != n_exp) begin failures++; $display("FAIL sof_n got=%0d exp=%0d", n_line, n_exp); end
  endtask

  task automatic test_zlp();
    send(4'hB, 11'h0, 7'd0, 0, 0);
    checks++;
    if (dec_v[31:0] !== 32'h00004B80 || dec_n != 32) begin failures++; $display("FAIL zlp_bytes got=%h/%0d exp=00004b80/32", dec_v[31:0], dec_n); end
    checks++;
    if (eop_cyc != 35 || rdy_cyc != 36) begin failures++; $display("FAIL zlp_eop got=%0d/%0d exp=35/36", eop_cyc, rdy_cyc); end
  endtask

  task automatic test_data_ff();
    for (int i = 0; i < 8; i++) wr(i, 8'hFF);
    send(4'h3, 11'h0, 7'd8, 0, 0);
    d = first_diff();
    checks++;
    if (d != -1) begin failures++; $display("FAIL ff_bits got=diff_at_%0d exp=none", d); end
    checks++;
    if (first_stuff != 20) begin failures++; $display("FAIL ff_first_stuff got=%0d exp=20", first_stuff); end
    checks++;
    if (stuff_cnt < 11 || n_line != n_exp) begin failures++; $display("FAIL ff_n got=%0d/%0d exp=%0d/>=11", n_line, stuff_cnt, n_exp); end
    checks++;
    if (eop_cyc != n_exp + 3) begin failures++; $display("FAIL ff_eop got=%0d exp=%0d", eop_cyc, n_exp + 3); end
  endtask

  task automatic test_max();
    send(4'hB, 11'h0, 7'd70, 0, 0);
    d = first_diff();
    checks++;
    if (d != -1 || dec_n != 544) begin failures++; $display("FAIL max_bits got=diff_at_%0d/len_%0d exp=none/544", d, dec_n); end
    checks++;
    if (rdy_cyc != n_exp + 4) begin failures++; $display("FAIL max_ready got=%0d exp=%0d", rdy_cyc, n_exp + 4); end
  endtask

  task automatic test_wr_busy();
    bit quiet = 1;
    send(4'h3, 11'h0, 7'd4, 0, 1);
    d = first_diff();
    checks++;
    if (d != -1) begin failures++; $display("FAIL busy_wr_bits got=diff_at_%0d exp=none", d); end
    repeat (3) begin
      if (oe !== 1'b0 || ready !== 1'b1) quiet = 0;
      @(negedge clk);
    end
    checks++;
    if (!quiet) begin failures++; $display("FAIL busy_valid_queued got=launch exp=idle"); end
    send(4'h3, 11'h0, 7'd4, 0, 0);
    d = first_diff();
    checks++;
    if (d != -1) begin failures++; $display("FAIL busy_wr_next got=diff_at_%0d exp=none", d); end
  endtask

  task automatic test_abort();
    bit held = 1;
    for (int i = 0; i < 8; i++) wr(i, 8'h00);
    send(4'h3, 11'h0, 7'd8, 34, 0);
`ifdef USBFS_PKT_TX_ABORT_EN
    for (int c = 35; c <= 42; c++) if (lv[c] !== lv[34]) held = 0;
    checks++;
    if (!held || stuff_err == 0) begin failures++; $display("FAIL abort_hold got=held:%0d err:%0d exp=held:1 err:>0", held, stuff_err); end
    checks++;
    if (eop_cyc != 45 || lv[43] !== 2'b00 || lv[44] !== 2'b00) begin failures++; $display("FAIL abort_eop got=%0d exp=45", eop_cyc); end
    checks++;
    if (!abt_seen || !j_ok) begin failures++; $display("FAIL abort_flag got=%0d exp=1", abt_seen); end
`else
    d = first_diff();
    checks++;
    if (d != -1 || !held) begin failures++; $display("FAIL abort_ignored got=diff_at_%0d exp=none", d); end
    checks++;
    if (abt_seen) begin failures++; $display("FAIL abort_flag got=1 exp=0"); end
`endif
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    pid = 4'h2; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (11) @(negedge clk);
    checks++;
    if (oe !== 1'b1 || ready !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=10", {oe, ready}); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({dp, dn, oe, ready} !== 4'b1001) begin failures++; $display("FAIL rst_mid_line got=%b exp=1001", {dp, dn, oe, ready}); end
    @(negedge clk);
    rst_n = 1'b1;
    send(4'h2, 11'h0, 7'd0, 0, 0);
    checks++;
    if (dec_v[15:0] !== 16'hD280 || eop_cyc != 19) begin failures++; $display("FAIL rst_mid_after got=%h/%0d exp=d280/19", dec_v[15:0], eop_cyc); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_ack();
    test_setup();
    test_sof();
    test_zlp();
    test_data_ff();
    test_max();
    test_wr_busy();
    test_abort();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
